// File: rtl/reg_file_32x32.sv
// 32-entry integer register file: two combinational read ports with same-cycle
// write forwarding, one synchronous write port, optional hardwired-zero r0.
module reg_file_32x32 #(
  parameter int DATA_W  = 32,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              RegWrite,
  input  logic [4:0]        WriteAddr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [4:0]        ReadAddr0,
  input  logic [4:0]        ReadAddr1,
  output logic [DATA_W-1:0] ReadData0,
  output logic [DATA_W-1:0] ReadData1,
  output logic [31:0]       WriteEn
);

  logic [DATA_W-1:0] regs [32];
  logic              wr_fwd;
  logic              byp0;
  logic              byp1;

  // Selects the value seen on a read port: hardwired zero, forwarded write
  // data, or the stored word, in that priority order.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [4:0]        addr,
    input logic              hit,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] res;
    if (ZERO_R0 && (addr == 5'd0))
      res = '0;
    else if (hit)
      res = wdata;
    else
      res = stored;
    return res;
  endfunction

  always_comb begin
    WriteEn = '0;
    for (int i = 0; i < 32; i++)
      WriteEn[i] = RegWrite && (WriteAddr == 5'(i));
    if (ZERO_R0)
      WriteEn[0] = 1'b0;
  end

  // Forwarding is only legal when the write will actually land this edge.
  always_comb begin
    wr_fwd = RegWrite && !Reset && !(ZERO_R0 && (WriteAddr == 5'd0));
    byp0   = wr_fwd && (ReadAddr0 == WriteAddr);
    byp1   = wr_fwd && (ReadAddr1 == WriteAddr);
  end

  // Storage: reset clears every word so no X ever reaches the read muxes.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < 32; i++) begin
      if (Reset)
        regs[i] <= '0;
      else if (WriteEn[i])
        regs[i] <= WriteData;
    end
  end

  always_comb begin
    ReadData0 = read_port(ReadAddr0, byp0, WriteData, regs[ReadAddr0]);
    ReadData1 = read_port(ReadAddr1, byp1, WriteData, regs[ReadAddr1]);
  end

endmodule

// File: tb/tb_reg_file_32x32.sv
// Self-checking bench for reg_file_32x32: directed scenarios plus a randomized
// regression against an array-based reference model.
module tb_reg_file_32x32;

  localparam bit ZERO_R0 = 1'b1;

  logic        Clk;
  logic        Reset;
  logic        RegWrite;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic [4:0]  ReadAddr0;
  logic [4:0]  ReadAddr1;
  logic [31:0] ReadData0;
  logic [31:0] ReadData1;
  logic [31:0] WriteEn;

  logic [31:0] model [32];
  int passed;
  int total;

  reg_file_32x32 #(.DATA_W(32), .ZERO_R0(ZERO_R0)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .RegWrite  (RegWrite),
    .WriteAddr (WriteAddr),
    .WriteData (WriteData),
    .ReadAddr0 (ReadAddr0),
    .ReadAddr1 (ReadAddr1),
    .ReadData0 (ReadData0),
    .ReadData1 (ReadData1),
    .WriteEn   (WriteEn)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Value a read port should show right now, from the architectural rules.
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (ZERO_R0 && a == 5'd0) return 32'h0;
    if (RegWrite && !Reset && a == WriteAddr) return WriteData;
    return model[a];
  endfunction

  function automatic logic [31:0] exp_we();
    if (!RegWrite) return 32'h0;
    if (ZERO_R0 && WriteAddr == 5'd0) return 32'h0;
    return 32'h1 << WriteAddr;
  endfunction

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    @(posedge Clk);
    if (Reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (RegWrite && !(ZERO_R0 && WriteAddr == 5'd0)) begin
      model[WriteAddr] = WriteData;
    end
    #1;
  endtask

  task automatic idle();
    Reset = 1'b0; RegWrite = 1'b0; WriteAddr = 5'd0; WriteData = 32'h0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; RegWrite = 1'b0;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ReadAddr0 = 5'(i); ReadAddr1 = 5'(31 - i);
      #1;
      total++;
      if (ReadData0 !== 32'h0) $display("FAIL reset_rd0 addr=%0d got=%h want=%h", i, ReadData0, 32'h0);
      else passed++;
      total++;
      if (ReadData1 !== 32'h0) $display("FAIL reset_rd1 addr=%0d got=%h want=%h", 31 - i, ReadData1, 32'h0);
      else passed++;
      total++;
      if (WriteEn !== 32'h0) $display("FAIL reset_we got=%h want=%h", WriteEn, 32'h0);
      else passed++;
    end
  endtask

  task automatic test_write_readback();
    for (int i = 1; i < 32; i++) begin
      RegWrite = 1'b1; WriteAddr = 5'(i); WriteData = 32'hA5A5_0000 + i;
      ReadAddr0 = 5'((i + 3) % 32); ReadAddr1 = 5'(i);
      #1;
      total++;
      if (WriteEn !== (32'h1 << i)) $display("FAIL wb_we idx=%0d got=%h want=%h", i, WriteEn, 32'h1 << i);
      else passed++;
      tick();
    end
    idle();
    for (int i = 0; i < 32; i++) begin
      ReadAddr0 = 5'(i); ReadAddr1 = 5'(i);
      #1;
      total++;
      if (ReadData0 !== ((i == 0) ? 32'h0 : 32'hA5A5_0000 + i))
        $display("FAIL wb_rd0 idx=%0d got=%h want=%h", i, ReadData0, (i == 0) ? 32'h0 : 32'hA5A5_0000 + i);
      else passed++;
      total++;
      if (ReadData1 !== ((i == 0) ? 32'h0 : 32'hA5A5_0000 + i))
        $display("FAIL wb_rd1 idx=%0d got=%h want=%h", i, ReadData1, (i == 0) ? 32'h0 : 32'hA5A5_0000 + i);
      else passed++;
    end
  endtask

  task automatic test_zero_reg();
    RegWrite = 1'b1; WriteAddr = 5'd0; WriteData = 32'hFFFF_FFFF;
    ReadAddr0 = 5'd0; ReadAddr1 = 5'd0;
    #1;
    total++;
    if (ReadData0 !== 32'h0) $display("FAIL r0_rd0_same got=%h want=%h", ReadData0, 32'h0);
    else passed++;
    total++;
    if (WriteEn !== 32'h0) $display("FAIL r0_we got=%h want=%h", WriteEn, 32'h0);
    else passed++;
    tick();
    idle();
    #1;
    total++;
    if (ReadData0 !== 32'h0) $display("FAIL r0_rd0_after got=%h want=%h", ReadData0, 32'h0);
    else passed++;
    total++;
    if (ReadData1 !== 32'h0) $display("FAIL r0_rd1_after got=%h want=%h", ReadData1, 32'h0);
    else passed++;
  endtask

  task automatic test_bypass();
    RegWrite = 1'b1; WriteAddr = 5'd7; WriteData = 32'h1111_1111;
    tick();
    WriteData = 32'h2222_2222; ReadAddr0 = 5'd7; ReadAddr1 = 5'd7;
    #1;
    total++;
    if (ReadData0 !== 32'h2222_2222) $display("FAIL byp_rd0_pre got=%h want=%h", ReadData0, 32'h2222_2222);
    else passed++;
    total++;
    if (ReadData1 !== 32'h2222_2222) $display("FAIL byp_rd1_pre got=%h want=%h", ReadData1, 32'h2222_2222);
    else passed++;
    tick();
    RegWrite = 1'b0;
    #1;
    total++;
    if (ReadData0 !== 32'h2222_2222) $display("FAIL byp_rd0_post got=%h want=%h", ReadData0, 32'h2222_2222);
    else passed++;
    total++;
    if (ReadData1 !== 32'h2222_2222) $display("FAIL byp_rd1_post got=%h want=%h", ReadData1, 32'h2222_2222);
    else passed++;
    RegWrite = 1'b1; WriteData = 32'h1111_1111;
    tick();
    RegWrite = 1'b0; WriteData = 32'h2222_2222;
    #1;
    total++;
    if (ReadData0 !== 32'h1111_1111) $display("FAIL nobyp_rd0 got=%h want=%h", ReadData0, 32'h1111_1111);
    else passed++;
    total++;
    if (ReadData1 !== 32'h1111_1111) $display("FAIL nobyp_rd1 got=%h want=%h", ReadData1, 32'h1111_1111);
    else passed++;
    total++;
    if (WriteEn !== 32'h0) $display("FAIL nobyp_we got=%h want=%h", WriteEn, 32'h0);
    else passed++;
    idle();
  endtask

  task automatic test_reset_collision();
    RegWrite = 1'b1; WriteAddr = 5'd5; WriteData = 32'hDEAD_BEEF;
    tick();
    Reset = 1'b1; WriteData = 32'h1234_5678; ReadAddr0 = 5'd5; ReadAddr1 = 5'd7;
    #1;
    total++;
    if (ReadData0 !== 32'hDEAD_BEEF) $display("FAIL rstcol_rd0_pre got=%h want=%h", ReadData0, 32'hDEAD_BEEF);
    else passed++;
    tick();
    idle();
    #1;
    total++;
    if (ReadData0 !== 32'h0) $display("FAIL rstcol_rd0_post got=%h want=%h", ReadData0, 32'h0);
    else passed++;
    total++;
    if (ReadData1 !== 32'h0) $display("FAIL rstcol_rd1_post got=%h want=%h", ReadData1, 32'h0);
    else passed++;
    // First cycle after reset must behave normally.
    RegWrite = 1'b1; WriteAddr = 5'd5; WriteData = 32'h0BAD_F00D;
    tick();
    idle();
    #1;
    total++;
    if (ReadData0 !== 32'h0BAD_F00D) $display("FAIL rstcol_after got=%h want=%h", ReadData0, 32'h0BAD_F00D);
    else passed++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 10000; n++) begin
      Reset     = ($urandom_range(0, 49) == 0);
      RegWrite  = $urandom_range(0, 1);
      WriteAddr = 5'($urandom_range(0, 31));
      WriteData = $urandom;
      ReadAddr0 = ($urandom_range(0, 3) == 0) ? WriteAddr : 5'($urandom_range(0, 31));
      ReadAddr1 = ($urandom_range(0, 3) == 0) ? WriteAddr : 5'($urandom_range(0, 31));
      #1;
      total++;
      if (ReadData0 !== exp_rd(ReadAddr0))
        $display("FAIL rand_rd0 cyc=%0d addr=%0d got=%h want=%h", n, ReadAddr0, ReadData0, exp_rd(ReadAddr0));
      else passed++;
      total++;
      if (ReadData1 !== exp_rd(ReadAddr1))
        $display("FAIL rand_rd1 cyc=%0d addr=%0d got=%h want=%h", n, ReadAddr1, ReadData1, exp_rd(ReadAddr1));
      else passed++;
      total++;
      if (WriteEn !== exp_we())
        $display("FAIL rand_we cyc=%0d got=%h want=%h", n, WriteEn, exp_we());
      else passed++;
      tick();
    end
    idle();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    idle();
    ReadAddr0 = 5'd0; ReadAddr1 = 5'd0;
    @(posedge Clk); #1;
    test_reset();
    test_write_readback();
    test_zero_reg();
    test_bypass();
    test_reset_collision();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
